// File: rtl/riscv_pkg.sv
// Shared types and constants for the write-back retire monitor.
// State encoding, default halt word and trace-entry sizing live here.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] HALT_INST_DEF = 32'h0000_0033;
  localparam int          TRACE_W       = 3 * XLEN_DEF + 1;

  function automatic int entry_width(int xlen);
    return 3 * xlen + 1;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_retire_monitor_if.sv
// Write-back retire bus plus trace read-out port.
// The pipeline/driver side is master; the monitor is slave.
interface pipe_retire_monitor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            valid_w;
  logic [XLEN-1:0] inst_w;
  logic [XLEN-1:0] pc_w;
  logic [XLEN-1:0] wb_w;
  logic            RegWEn_w;
  logic            rd_en;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_inst;
  logic [XLEN-1:0] rd_wb;
  logic            rd_we;
  logic            empty;
  logic            full;
  logic [CW-1:0]   count;

  modport master (
    output valid_w, inst_w, pc_w, wb_w,
    output RegWEn_w, rd_en,
    input  rd_pc, rd_inst, rd_wb, rd_we,
    input  empty, full, count
  );

  modport slave (
    input  valid_w, inst_w, pc_w, wb_w,
    input  RegWEn_w, rd_en,
    output rd_pc, rd_inst, rd_wb, rd_we,
    output empty, full, count
  );

endinterface

// File: rtl/trace_fifo.sv
// Show-ahead ring buffer for retired-instruction trace entries.
// Extended pointers give occupancy without a separate counter.
module trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = TRACE_W,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o
);
  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [AW-1:0]    wa, ra;
  logic             we, pop_ok;

  assign wa      = wp_q[AW-1:0];
  assign ra      = rp_q[AW-1:0];
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wa == ra);
  assign count_o = wp_q - rp_q;
  assign pop_ok  = pop_i && !empty_o;

  // When empty, keep presenting the last popped entry (zero after reset).
  assign data_o = empty_o ? last_q : mem_q[ra];

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    last_d = last_q;
    we     = 1'b0;
    ovf_o  = 1'b0;
    if (clr_i) begin
      wp_d   = '0;
      rp_d   = '0;
      last_d = '0;
    end else begin
      if (pop_ok) begin
        rp_d   = rp_q + ONE;
        last_d = mem_q[ra];
      end
      if (push_i) begin
        if (full_o && !pop_ok) begin
          ovf_o = 1'b1;
          if (OVERWRITE) begin
            we   = 1'b1;
            wp_d = wp_q + ONE;
            rp_d = rp_q + ONE;
          end
        end else begin
          we   = 1'b1;
          wp_d = wp_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      last_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= data_i;
  end

endmodule

// File: rtl/pipe_retire_monitor.sv
// Retire monitor: traces write-back, counts cycles and retires,
// and stops on the halt instruction or a retire watchdog.
module pipe_retire_monitor
  import riscv_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              DEPTH     = 16,
  parameter logic [XLEN-1:0] HALT_INST = XLEN'(HALT_INST_DEF),
  parameter int              TIMEOUT   = 4096,
  parameter bit              OVERWRITE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_pc,
  input  logic        clr,
  pipe_retire_monitor_if.slave bus,
  output logic        overflow,
  output logic        halted,
  output logic        timed_out,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
);
  localparam int W  = entry_width(XLEN);
  localparam int IW = $clog2(TIMEOUT);

  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   ret_q, ret_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          ovf_q, ovf_d;
  logic          push, fifo_ovf;
  logic [W-1:0]  wr_ent, rd_ent;

  assign wr_ent = {bus.pc_w, bus.inst_w,
                   bus.wb_w, bus.RegWEn_w};
  assign {bus.rd_pc, bus.rd_inst,
          bus.rd_wb, bus.rd_we} = rd_ent;

  trace_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (W),
    .OVERWRITE(OVERWRITE)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_pc),
    .clr_i  (clr),
    .push_i (push),
    .data_i (wr_ent),
    .pop_i  (bus.rd_en),
    .data_o (rd_ent),
    .empty_o(bus.empty),
    .full_o (bus.full),
    .count_o(bus.count),
    .ovf_o  (fifo_ovf)
  );

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    ret_d   = ret_q;
    cyc_d   = cyc_q;
    ovf_d   = ovf_q | fifo_ovf;
    push    = 1'b0;
    if (clr) begin
      state_d = ST_RUN;
      idle_d  = '0;
      ret_d   = '0;
      cyc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          cyc_d = sat_inc(cyc_q);
          // A retire always resets the watchdog, so halt beats timeout.
          if (bus.valid_w) begin
            push   = 1'b1;
            ret_d  = sat_inc(ret_q);
            idle_d = '0;
            if (bus.inst_w == HALT_INST) state_d = ST_HALTED;
          end else if (idle_q == IW'(TIMEOUT - 1)) begin
            state_d = ST_TIMEOUT;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
        ST_HALTED:  ;
        ST_TIMEOUT: ;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_pc) begin
    if (!rst_pc) begin
      state_q <= ST_RUN;
      idle_q  <= '0;
      ret_q   <= '0;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      ret_q   <= ret_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow    = ovf_q;
  assign halted      = (state_q == ST_HALTED);
  assign timed_out   = (state_q == ST_TIMEOUT);
  assign retired_cnt = ret_q;
  assign cycle_cnt   = cyc_q;

endmodule
